// File: rtl/raw_stream_pkg.sv
// Shared types and default sizing for the raw stream source and its buffer.
package raw_stream_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/raw_stream_fifo.sv
// Flop-based circular buffer with a registered head word for the raw stream source.
module raw_stream_fifo
   import raw_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // The head is only re-registered while words are buffered, so dout holds on empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (count != '0) begin
            dout <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/raw_stream_source.sv
// Frame-oriented word source: buffers host words and hands them to the accelerator on pull strobes.
module raw_stream_source
   import raw_stream_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int FRAME_LEN = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             raw_oc_raw_update_0_read_en,
   output logic [WIDTH-1:0] raw_oc_raw_update_0_read,
   output logic             frame_done,
   output logic             underflow,
   output logic [31:0]      words_sent
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t          state;
   state_t          next_state;
   logic [CW-1:0]   fifo_count;
   logic            push;
   logic            pop;
   logic            starved;
   logic            last_pop;

   // rst_n is active-high despite its name.
   assign in_ready = (fifo_count < CW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == RUN) && raw_oc_raw_update_0_read_en && (fifo_count != '0);
   assign starved  = (state == RUN) && raw_oc_raw_update_0_read_en && (fifo_count == '0);
   assign last_pop = pop && (words_sent == 32'(FRAME_LEN - 1));

   raw_stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (in_data),
      .dout  (raw_oc_raw_update_0_read),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (flush) next_state = RUN;
         RUN: begin
            if (flush) begin
               next_state = RUN;
            end else if (last_pop) begin
               next_state = DONE;
            end
         end
         DONE:    if (flush) next_state = RUN;
         default: next_state = IDLE;
      endcase
   end

   // flush restarts the frame count and clears the sticky flag, overriding a coincident pop.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         words_sent <= '0;
         frame_done <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         frame_done <= last_pop && !flush;
         if (flush) begin
            words_sent <= '0;
            underflow  <= 1'b0;
         end else begin
            if (pop) begin
               words_sent <= words_sent + 32'd1;
            end
            if (starved) begin
               underflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_raw_stream_source.sv
// Directed self-checking bench for raw_stream_source with a 4-word frame.
module tb_raw_stream_source;
   import raw_stream_pkg::*;

   localparam int WIDTH     = 16;
   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             read_en;
   logic [WIDTH-1:0] read_data;
   logic             frame_done;
   logic             underflow;
   logic [31:0]      words_sent;

   int check_count = 0;
   int error_count = 0;

   raw_stream_source #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .flush                       (flush),
      .in_valid                    (in_valid),
      .in_data                     (in_data),
      .in_ready                    (in_ready),
      .raw_oc_raw_update_0_read_en (read_en),
      .raw_oc_raw_update_0_read    (read_data),
      .frame_done                  (frame_done),
      .underflow                   (underflow),
      .words_sent                  (words_sent)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic rs, input logic fl, input logic v,
                                input logic [WIDTH-1:0] d, input logic re);
      rst_n    = rs;
      flush    = fl;
      in_valid = v;
      in_data  = d;
      read_en  = re;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; read_en = 1'b0;

      // Reset state
      applyStimulus(1, 0, 0, 16'h0, 0);
      applyStimulus(1, 0, 0, 16'h0, 0);
      checkOutput("rst_read", 32'(read_data), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("rst_underflow", 32'(underflow), 32'h0);
      checkOutput("rst_words_sent", words_sent, 32'h0);
      checkOutput("rst_state", 32'(dut.state), 32'(IDLE));

      // Pushes in IDLE; head word shows one cycle after the first push edge
      applyStimulus(0, 0, 1, 16'h0001, 0);
      checkOutput("latency_before", 32'(read_data), 32'h0);
      applyStimulus(0, 0, 1, 16'h0002, 0);
      checkOutput("latency_after", 32'(read_data), 32'h0001);
      applyStimulus(0, 0, 1, 16'h0003, 0);
      applyStimulus(0, 0, 0, 16'h0, 1);
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("idle_count", 32'(dut.fifo_count), 32'd3);
      checkOutput("idle_words_sent", words_sent, 32'h0);
      checkOutput("idle_underflow", 32'(underflow), 32'h0);
      checkOutput("idle_read", 32'(read_data), 32'h0001);

      // Flush, then three pulls
      applyStimulus(0, 1, 0, 16'h0, 0);
      checkOutput("flush_state", 32'(dut.state), 32'(RUN));
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("pull1_read", 32'(read_data), 32'h0001);
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("pull2_read", 32'(read_data), 32'h0002);
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("pull3_read", 32'(read_data), 32'h0003);
      checkOutput("pull3_words_sent", words_sent, 32'd3);

      // Pull while empty
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("uflow_set", 32'(underflow), 32'h1);
      checkOutput("uflow_read_hold", 32'(read_data), 32'h0003);
      checkOutput("uflow_words_sent", words_sent, 32'd3);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("uflow_sticky", 32'(underflow), 32'h1);
      applyStimulus(0, 1, 0, 16'h0, 0);
      checkOutput("uflow_cleared", 32'(underflow), 32'h0);
      checkOutput("flush_words_sent", words_sent, 32'h0);

      // Fill the buffer
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 0, 1, 16'(16'h0100 + i), 0);
      end
      checkOutput("full_in_ready", 32'(in_ready), 32'h0);
      checkOutput("full_count", 32'(dut.fifo_count), 32'd16);
      checkOutput("full_read", 32'(read_data), 32'h0100);

      // Offered word with pull on a full buffer, then push+pop together
      applyStimulus(0, 0, 1, 16'h0200, 1);
      checkOutput("full_pop_count", 32'(dut.fifo_count), 32'd15);
      checkOutput("full_pop_in_ready", 32'(in_ready), 32'h1);
      applyStimulus(0, 0, 1, 16'h0200, 1);
      checkOutput("pushpop_count", 32'(dut.fifo_count), 32'd15);
      checkOutput("pushpop_read", 32'(read_data), 32'h0101);
      checkOutput("pushpop_words_sent", words_sent, 32'd2);

      // Finish the frame
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("pop3_frame_done", 32'(frame_done), 32'h0);
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("pop4_frame_done", 32'(frame_done), 32'h1);
      checkOutput("pop4_state", 32'(dut.state), 32'(DONE));
      checkOutput("pop4_words_sent", words_sent, 32'd4);
      checkOutput("pop4_read", 32'(read_data), 32'h0103);
      applyStimulus(0, 0, 0, 16'h0, 1);
      checkOutput("done_pulse_end", 32'(frame_done), 32'h0);
      checkOutput("done_ignored_count", 32'(dut.fifo_count), 32'd13);
      checkOutput("done_ignored_ws", words_sent, 32'd4);
      checkOutput("done_no_uflow", 32'(underflow), 32'h0);
      checkOutput("done_head", 32'(read_data), 32'h0104);

      // Flush from DONE, then flush coincident with a pop
      applyStimulus(0, 1, 0, 16'h0, 1);
      checkOutput("redone_state", 32'(dut.state), 32'(RUN));
      checkOutput("redone_count", 32'(dut.fifo_count), 32'd13);
      applyStimulus(0, 1, 0, 16'h0, 1);
      checkOutput("flushpop_ws", words_sent, 32'h0);
      checkOutput("flushpop_count", 32'(dut.fifo_count), 32'd12);

      // Reset mid-frame beats flush, push and pull
      applyStimulus(1, 1, 1, 16'h0555, 1);
      checkOutput("midrst_count", 32'(dut.fifo_count), 32'd0);
      checkOutput("midrst_read", 32'(read_data), 32'h0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("midrst_state", 32'(dut.state), 32'(IDLE));
      checkOutput("midrst_ws", words_sent, 32'h0);

      // Push and pull together on an empty buffer
      applyStimulus(0, 1, 0, 16'h0, 0);
      applyStimulus(0, 0, 1, 16'hABCD, 1);
      checkOutput("empty_pp_uflow", 32'(underflow), 32'h1);
      checkOutput("empty_pp_count", 32'(dut.fifo_count), 32'd1);
      checkOutput("empty_pp_ws", words_sent, 32'h0);
      applyStimulus(0, 0, 0, 16'h0, 0);
      checkOutput("empty_pp_read", 32'(read_data), 32'hABCD);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, error_count);
      $finish;
   end

endmodule
